lpif_test_sequencer: RTL



---
 rtl/lpif_test_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/lpif_test_sequencer.sv
// lpif_test_sequencer: CSR master that runs one LPIF loopback test (delays, link poll, flit enable, status poll).
// Optional macro LPIF_SEQ_READBACK_EN adds a readback check after each delay write.
module lpif_test_sequencer #(
    parameter logic [31:0] DELAY_X        = 32'd16,
    parameter logic [31:0] DELAY_Y        = 32'd32,
    parameter logic [31:0] DELAY_Z        = 32'd64,
    parameter int          POLL_GAP       = 8,
    parameter int          RSP_WAIT       = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [15:0] csr_addr,
    output logic        csr_wr_en,
    output logic        csr_rd_en,
    output logic [31:0] csr_wr_data,
    input  logic [31:0] csr_rd_data,
    input  logic        csr_rd_dvalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  err_code
);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int RW = $clog2(RSP_WAIT + 1);

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_LOST    = 3'd2;
    localparam logic [2:0] ERR_ALIGN   = 3'd3;
    localparam logic [2:0] ERR_CHK     = 3'd5;
    localparam logic [2:0] ERR_ABORT   = 3'd6;

    typedef enum logic [3:0] {
        IDLE, WR_X, WR_Y, WR_Z, LNK_RD, LNK_WAIT, LNK_GAP, EN_WR,
        STS_RD, STS_WAIT, STS_GAP, CLR_EN, DONE
`ifdef LPIF_SEQ_READBACK_EN
        , RB_RD, RB_WAIT
`endif
    } state_t;

    state_t          state, next_state;
    logic [31:0]     wd_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [RW-1:0]   rsp_cnt;
    logic            term, term_pass;
    logic [2:0]      term_err;
    logic            timed_out, gap_last, rsp_lost, in_run, wait_state;
    logic            rd_data_unused;

    assign timed_out      = (wd_cnt >= TIMEOUT_CYCLES);
    assign gap_last       = (gap_cnt == GW'(POLL_GAP - 1));
    assign rsp_lost       = (rsp_cnt == RW'(RSP_WAIT));
    assign in_run         = (state != IDLE) && (state != CLR_EN) && (state != DONE);
    assign busy           = (state != IDLE) && (state != DONE);
    assign done           = (state == DONE);
    assign rd_data_unused = ^csr_rd_data[31:6];

`ifdef LPIF_SEQ_READBACK_EN
    localparam logic [2:0] ERR_RB = 3'd4;
    logic [1:0]  rb_idx;
    logic [15:0] rb_addr;
    logic [31:0] rb_data;

    assign wait_state = (state == LNK_WAIT) || (state == STS_WAIT) || (state == RB_WAIT);
    assign rb_addr    = 16'h2000 + {12'h000, rb_idx, 2'b00};
    assign rb_data    = (rb_idx == 2'd0) ? DELAY_X : (rb_idx == 2'd1) ? DELAY_Y : DELAY_Z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              rb_idx <= 2'd0;
        else if (state == WR_X)  rb_idx <= 2'd0;
        else if (state == WR_Y)  rb_idx <= 2'd1;
        else if (state == WR_Z)  rb_idx <= 2'd2;
    end
`else
    assign wait_state = (state == LNK_WAIT) || (state == STS_WAIT);
`endif

    always_comb begin
        next_state  = state;
        term        = 1'b0;
        term_pass   = 1'b0;
        term_err    = ERR_NONE;
        csr_addr    = 16'h0;
        csr_wr_en   = 1'b0;
        csr_rd_en   = 1'b0;
        csr_wr_data = 32'h0;
        case (state)
            IDLE: if (start) next_state = WR_X;
            WR_X: begin
                csr_wr_en = 1'b1; csr_addr = 16'h2000; csr_wr_data = DELAY_X;
`ifdef LPIF_SEQ_READBACK_EN
                next_state = RB_RD;
`else
                next_state = WR_Y;
`endif
            end
            WR_Y: begin
                csr_wr_en = 1'b1; csr_addr = 16'h2004; csr_wr_data = DELAY_Y;
`ifdef LPIF_SEQ_READBACK_EN
                next_state = RB_RD;
`else
                next_state = WR_Z;
`endif
            end
            WR_Z: begin
                csr_wr_en = 1'b1; csr_addr = 16'h2008; csr_wr_data = DELAY_Z;
`ifdef LPIF_SEQ_READBACK_EN
                next_state = RB_RD;
`else
                next_state = LNK_RD;
`endif
            end
`ifdef LPIF_SEQ_READBACK_EN
            RB_RD: begin
                csr_rd_en = 1'b1; csr_addr = rb_addr; next_state = RB_WAIT;
            end
            RB_WAIT: begin
                if (csr_rd_dvalid) begin
                    if (csr_rd_data != rb_data)  begin term = 1'b1; term_err = ERR_RB; end
                    else if (rb_idx == 2'd0)     next_state = WR_Y;
                    else if (rb_idx == 2'd1)     next_state = WR_Z;
                    else                         next_state = LNK_RD;
                end else if (rsp_lost) begin
                    term = 1'b1; term_err = ERR_LOST;
                end
            end
`endif
            LNK_RD: begin
                csr_rd_en = 1'b1; csr_addr = 16'h1008; next_state = LNK_WAIT;
            end
            LNK_WAIT: begin
                if (csr_rd_dvalid) begin
                    if (!csr_rd_data[5])                 begin term = 1'b1; term_err = ERR_ALIGN; end
                    else if (csr_rd_data[5:0] == 6'h3F)  next_state = EN_WR;
                    else                                 next_state = LNK_GAP;
                end else if (rsp_lost) begin
                    term = 1'b1; term_err = ERR_LOST;
                end
            end
            LNK_GAP: if (gap_last) next_state = LNK_RD;
            EN_WR: begin
                csr_wr_en = 1'b1; csr_addr = 16'h1000; csr_wr_data = 32'h1; next_state = STS_RD;
            end
            STS_RD: begin
                csr_rd_en = 1'b1; csr_addr = 16'h1004; next_state = STS_WAIT;
            end
            STS_WAIT: begin
                if (csr_rd_dvalid) begin
                    if (!csr_rd_data[3])                  begin term = 1'b1; term_err = ERR_ALIGN; end
                    else if (!csr_rd_data[2])             next_state = STS_GAP;
                    else if (csr_rd_data[1:0] == 2'b11)   begin term = 1'b1; term_pass = 1'b1; end
                    else                                  begin term = 1'b1; term_err = ERR_CHK; end
                end else if (rsp_lost) begin
                    term = 1'b1; term_err = ERR_LOST;
                end
            end
            STS_GAP: if (gap_last) next_state = STS_RD;
            CLR_EN: begin
                csr_wr_en = 1'b1; csr_addr = 16'h1000; csr_wr_data = 32'h0; next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // Abort and watchdog override whatever the current state decided, abort first.
        if (in_run && abort) begin
            term = 1'b1; term_pass = 1'b0; term_err = ERR_ABORT;
        end else if (in_run && timed_out) begin
            term = 1'b1; term_pass = 1'b0; term_err = ERR_TIMEOUT;
        end
        if (term) next_state = CLR_EN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt   <= 32'h0;
            gap_cnt  <= '0;
            rsp_cnt  <= '0;
            pass     <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (state == IDLE && start) begin
                wd_cnt   <= 32'h0;
                pass     <= 1'b0;
                err_code <= ERR_NONE;
            end else if (busy && !timed_out) begin
                wd_cnt <= wd_cnt + 32'd1;
            end
            if (term) begin
                pass     <= term_pass;
                err_code <= term_err;
            end
            if ((state == LNK_GAP || state == STS_GAP) && !gap_last) gap_cnt <= gap_cnt + GW'(1);
            else                                                     gap_cnt <= '0;
            // rsp_cnt holds the number of cycles elapsed since the read strobe.
            if (csr_rd_en)       rsp_cnt <= RW'(1);
            else if (wait_state) rsp_cnt <= rsp_cnt + RW'(1);
            else                 rsp_cnt <= '0;
        end
    end
endmodule
